multicycle_ctrl: RTL



---
 rtl/mctrl_pkg.sv | 41 ++++
 rtl/multicycle_ctrl_opclass.sv | 24 ++
 rtl/multicycle_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mctrl_pkg.sv
// mctrl_pkg: shared types and constants for the multi-cycle control FSM.
//   state_e    : FSM state encoding
//   opclass_e  : decoded instruction class
//   OP_*       : 6-bit opcode values of the supported instructions
//   ALUOP_*    : 3-bit ALU operation codes driven on ALUOp_o
package mctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_ADDR,
        ST_MEM,
        ST_MEMWB,
        ST_BRANCH,
        ST_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_ADDI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_ILLEGAL
    } opclass_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_ADDI  = 3'b011;
    localparam logic [2:0] ALUOP_BEQ   = 3'b001;
    localparam logic [2:0] ALUOP_ADD   = 3'b000;

endpackage

// File: rtl/multicycle_ctrl_opclass.sv
// mctrl_opclass: combinational opcode classifier.
//   op_i  [5:0] in  : opcode field of the IR
//   cls_o [2:0] out : opclass_e value (R, ADDI, LW, SW, BEQ, ILLEGAL)
module mctrl_opclass
    import mctrl_pkg::*;
(
    input  logic [5:0] op_i,
    output logic [2:0] cls_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives cls_o and no latch is inferred.
        cls_o = CLS_ILLEGAL;
        unique case (op_i)
            OP_RTYPE: cls_o = CLS_R;
            OP_ADDI:  cls_o = CLS_ADDI;
            OP_LW:    cls_o = CLS_LW;
            OP_SW:    cls_o = CLS_SW;
            OP_BEQ:   cls_o = CLS_BEQ;
            default:  cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the MIPS-subset CPU
// (R-type, addi, lw, sw, beq; any other opcode traps until reset).
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   instr_op_i[5:0]  IR opcode, sampled in DECODE
//   zero_i           ALU zero flag, used in BRANCH
//   imem_ack_i       instruction fetch done
//   dmem_ack_i       data access done
//   imem_req_o, dmem_read_o, dmem_write_o   memory requests
//   IRWrite_o, PCWrite_o, PCSrc_o           IR/PC controls
//   RegWrite_o, RegDst_o, ALUSrc_o, MemtoReg_o, ALUOp_o[2:0]  datapath controls
//   trap_o           illegal opcode seen (sticky until reset)
//   retired_cnt_o[31:0]  retired-instruction counter, only with MCTRL_PERF_EN
//
// Build option: define MCTRL_PERF_EN to add retired_cnt_o.
module multicycle_ctrl
    import mctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       zero_i,
    input  logic       imem_ack_i,
    input  logic       dmem_ack_i,
    output logic       imem_req_o,
    output logic       dmem_read_o,
    output logic       dmem_write_o,
    output logic       IRWrite_o,
    output logic       PCWrite_o,
    output logic       PCSrc_o,
    output logic       RegWrite_o,
    output logic       RegDst_o,
    output logic       ALUSrc_o,
    output logic       MemtoReg_o,
    output logic [2:0] ALUOp_o,
    output logic       trap_o
`ifdef MCTRL_PERF_EN
    ,
    output logic [31:0] retired_cnt_o
`endif
);

    state_e     state_q;
    opclass_e   class_q;
    logic [2:0] dec_cls;

    mctrl_opclass u_opclass (
        .op_i  (instr_op_i),
        .cls_o (dec_cls)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            class_q <= CLS_ILLEGAL;
        end else begin
            unique case (state_q)
                ST_IDLE:   state_q <= ST_FETCH;
                ST_FETCH:  if (imem_ack_i) state_q <= ST_DECODE;
                ST_DECODE: begin
                    class_q <= opclass_e'(dec_cls);
                    unique case (opclass_e'(dec_cls))
                        CLS_R, CLS_ADDI: state_q <= ST_EXEC;
                        CLS_LW, CLS_SW:  state_q <= ST_ADDR;
                        CLS_BEQ:         state_q <= ST_BRANCH;
                        default:         state_q <= ST_TRAP;
                    endcase
                end
                ST_EXEC:   state_q <= ST_WB;
                ST_WB:     state_q <= ST_FETCH;
                ST_ADDR:   state_q <= ST_MEM;
                ST_MEM: begin
                    if (dmem_ack_i)
                        state_q <= (class_q == CLS_LW) ? ST_MEMWB : ST_FETCH;
                end
                ST_MEMWB:  state_q <= ST_FETCH;
                ST_BRANCH: state_q <= ST_FETCH;
                ST_TRAP:   state_q <= ST_TRAP;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the registered state and class. The ack- and
    // zero-qualified strobes must follow the input in the same cycle, and the
    // async reset must kill requests immediately, so this stays combinational.
    always_comb begin
        imem_req_o   = 1'b0;
        dmem_read_o  = 1'b0;
        dmem_write_o = 1'b0;
        IRWrite_o    = 1'b0;
        PCWrite_o    = 1'b0;
        PCSrc_o      = 1'b0;
        RegWrite_o   = 1'b0;
        RegDst_o     = 1'b0;
        ALUSrc_o     = 1'b0;
        MemtoReg_o   = 1'b0;
        ALUOp_o      = ALUOP_ADD;
        trap_o       = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                imem_req_o = 1'b1;
                IRWrite_o  = imem_ack_i;
                PCWrite_o  = imem_ack_i;   // PCSrc_o stays 0: PC+4
            end
            ST_EXEC, ST_WB: begin
                if (class_q == CLS_R) begin
                    ALUOp_o  = ALUOP_RTYPE;
                    ALUSrc_o = 1'b0;
                end else begin
                    ALUOp_o  = ALUOP_ADDI;
                    ALUSrc_o = 1'b1;
                end
                if (state_q == ST_WB) begin
                    RegWrite_o = 1'b1;
                    RegDst_o   = (class_q == CLS_R);
                end
            end
            ST_ADDR: begin
                ALUOp_o  = ALUOP_ADD;
                ALUSrc_o = 1'b1;
            end
            ST_MEM: begin
                ALUOp_o      = ALUOP_ADD;
                ALUSrc_o     = 1'b1;
                dmem_read_o  = (class_q == CLS_LW);
                dmem_write_o = (class_q == CLS_SW);
            end
            ST_MEMWB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
            end
            ST_BRANCH: begin
                ALUOp_o   = ALUOP_BEQ;
                PCSrc_o   = 1'b1;
                PCWrite_o = zero_i;
            end
            ST_TRAP:  trap_o = 1'b1;
            default: ;
        endcase
    end

`ifdef MCTRL_PERF_EN
    logic        retire;
    logic [31:0] retired_d;
    logic [31:0] retired_q;

    // One pulse per completed instruction: the cycle leaving its last state.
    assign retire = (state_q == ST_WB) || (state_q == ST_MEMWB) ||
                    (state_q == ST_BRANCH) ||
                    ((state_q == ST_MEM) && dmem_ack_i && (class_q == CLS_SW));

    assign retired_d = retire ? retired_q + 32'd1 : retired_q;  // wraps naturally

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) retired_q <= '0;
        else        retired_q <= retired_d;
    end

    assign retired_cnt_o = retired_q;
`endif

endmodule
